// File: rtl/iq_sample_player.sv
// iq_sample_player: preloaded I/Q buffer played out as a strobed sample stream.
// A divider on CLK produces one out_strobe every P cycles while enabled; the
// buffer read is prefetched one cycle ahead so the sample is ready on the strobe.
module iq_sample_player #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024,
   parameter int DIV_W  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              s_RST,
   input  logic              enable,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_I,
   input  logic [DATA_W-1:0] wr_Q,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_mode,
   input  logic [ADDR_W:0]   num_samples,
   input  logic [DIV_W-1:0]  strobe_period,
   output logic [DATA_W-1:0] I_out,
   output logic [DATA_W-1:0] Q_out,
   output logic              out_strobe,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   sample_cnt,
   output logic [15:0]       loop_cnt
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [DIV_W-1:0]    div_q;
   logic [DIV_W-1:0]    period_q;
   logic [ADDR_W:0]     n_q;
   logic                loop_q;
   logic                fin_q;        // last single-shot strobe issued, DONE follows
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   i_out_q;
   logic [DATA_W-1:0]   q_out_q;
   logic                strobe_q;
   logic                busy_q;
   logic                done_q;
   logic [ADDR_W:0]     sample_cnt_q;
   logic [15:0]         loop_cnt_q;

   logic [ADDR_W:0]     n_clamped;
   logic [DIV_W-1:0]    period_fixed;
   logic                start_acc;
   logic                term;
   logic                fire;
   logic                last;
   logic                wr_fire;
   logic [DATA_W-1:0]   wr_lane [2];
   logic [DATA_W-1:0]   rd_i;
   logic [DATA_W-1:0]   rd_q;

   // Decode start/strobe conditions and the next read address (drives the RAM prefetch)
   always_comb begin
      n_clamped    = (num_samples > DEPTH_C) ? DEPTH_C : num_samples;
      period_fixed = (strobe_period == '0) ? DIV_W'(1) : strobe_period;
      start_acc    = (state_q != S_RUN) && start && (num_samples != '0);
      term         = (div_q == period_q - DIV_W'(1));
      fire         = (state_q == S_RUN) && !stop && !fin_q && enable && term;
      last         = fire && ((sample_cnt_q + (ADDR_W+1)'(1)) == n_q);
      wr_fire      = wr_en && !busy_q;
      wr_lane[0]   = wr_I;
      wr_lane[1]   = wr_Q;
      addr_d       = addr_q;
      if (start_acc) begin
         addr_d = '0;
      end else if (fire) begin
         addr_d = (last && loop_q) ? '0 : addr_q + ADDR_W'(1);
      end
   end

   // One RAM per lane: write port from the loader, registered read at the next address
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rd_data_q;

      // Loader write; playback never writes the buffer
      always_ff @(posedge CLK) begin
         if (wr_fire) begin
            mem[wr_addr] <= wr_lane[gi];
         end
      end

      // Prefetch read; a same-cycle write to the read address is forwarded
      always_ff @(posedge CLK) begin
         if (wr_fire && (wr_addr == addr_d)) begin
            rd_data_q <= wr_lane[gi];
         end else begin
            rd_data_q <= mem[addr_d];
         end
      end
   end

   assign rd_i = g_lane[0].rd_data_q;
   assign rd_q = g_lane[1].rd_data_q;

   // Playback FSM with divider, counters and registered outputs
   always_ff @(posedge CLK) begin
      if (s_RST) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         period_q     <= DIV_W'(1);
         n_q          <= '0;
         loop_q       <= 1'b0;
         fin_q        <= 1'b0;
         addr_q       <= '0;
         i_out_q      <= '0;
         q_out_q      <= '0;
         strobe_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sample_cnt_q <= '0;
         loop_cnt_q   <= '0;
      end else begin
         strobe_q <= 1'b0;
         addr_q   <= addr_d;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_acc) begin
                  state_q      <= S_RUN;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  n_q          <= n_clamped;
                  period_q     <= period_fixed;
                  loop_q       <= loop_mode;
                  fin_q        <= 1'b0;
                  div_q        <= '0;
                  sample_cnt_q <= '0;
                  loop_cnt_q   <= '0;
               end
            end
            S_RUN: begin
               if (stop) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (fin_q) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  fin_q   <= 1'b0;
               end else if (enable) begin
                  if (term) begin
                     div_q    <= '0;
                     strobe_q <= 1'b1;
                     i_out_q  <= rd_i;
                     q_out_q  <= rd_q;
                     if (last) begin
                        if (loop_cnt_q != 16'hFFFF) begin
                           loop_cnt_q <= loop_cnt_q + 16'd1;
                        end
                        if (loop_q) begin
                           sample_cnt_q <= '0;
                        end else begin
                           sample_cnt_q <= sample_cnt_q + (ADDR_W+1)'(1);
                           fin_q        <= 1'b1;
                        end
                     end else begin
                        sample_cnt_q <= sample_cnt_q + (ADDR_W+1)'(1);
                     end
                  end else begin
                     div_q <= div_q + DIV_W'(1);
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign I_out      = i_out_q;
   assign Q_out      = q_out_q;
   assign out_strobe = strobe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign sample_cnt = sample_cnt_q;
   assign loop_cnt   = loop_cnt_q;

endmodule
